// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL lock sequencer: state encoding,
// event-counter saturation value and counter sizing.
package pll_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam logic [7:0] CNT_SAT = 8'hFF;

  // Event counters stop at CNT_SAT instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == CNT_SAT) ? v : v + 8'd1;
  endfunction

  // The shared counter only ever reaches (largest parameter - 1).
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous status bit, cleared by a
// synchronous active-high reset.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Drives PLL reset, waits for lock with timeout/retry, qualifies lock stability
// and releases the core reset; lock loss in RUN restarts the sequence.
module pll_lock_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned RST_PULSE     = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int unsigned CNT_W = cnt_width(RST_PULSE, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             lk;
  state_t           fsm;
  logic [CNT_W-1:0] cnt;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(refclk),
    .rst(rst),
    .d  (locked),
    .q  (lk)
  );

  // FSM, shared dwell counter and event counters; port outputs are set on the
  // same edge as the state change so they never lag or lead it.
  always_ff @(posedge refclk) begin
    if (rst) begin
      fsm        <= ST_RESET;
      cnt        <= '0;
      pll_rst    <= 1'b1;
      core_reset <= 1'b1;
      ready      <= 1'b0;
      retry_cnt  <= 8'd0;
      loss_cnt   <= 8'd0;
    end else begin
      if (fsm != ST_RUN) cnt <= cnt + CNT_W'(1);
      unique case (fsm)
        ST_RESET: begin
          if (cnt == RST_LAST) begin
            fsm     <= ST_WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock beats the timeout when both land on the same cycle.
          if (lk) begin
            fsm <= ST_STABLE;
            cnt <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            fsm       <= ST_RESET;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            retry_cnt <= sat_inc(retry_cnt);
          end
        end
        ST_STABLE: begin
          // A drop on the terminal cycle still aborts qualification.
          if (!lk) begin
            fsm <= ST_WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == STABLE_LAST) begin
            fsm        <= ST_RUN;
            cnt        <= '0;
            core_reset <= 1'b0;
            ready      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!lk) begin
            fsm        <= ST_RESET;
            cnt        <= '0;
            pll_rst    <= 1'b1;
            core_reset <= 1'b1;
            ready      <= 1'b0;
            loss_cnt   <= sat_inc(loss_cnt);
          end
        end
        default: begin
          fsm <= ST_RESET;
          cnt <= '0;
        end
      endcase
    end
  end

  assign state = 2'(fsm);

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomized and directed bench for pll_lock_sequencer against a dwell-time
// reference model of the lock sequence.
module tb_pll_lock_sequencer;

  localparam int unsigned SS = 2;
  localparam int unsigned RP = 4;
  localparam int unsigned LT = 20;
  localparam int unsigned SC = 8;

  logic       refclk = 1'b0;
  logic       rst    = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst;
  logic       core_reset;
  logic       ready;
  logic [1:0] state;
  logic [7:0] retry_cnt;
  logic [7:0] loss_cnt;

  always #10 refclk = ~refclk;

  pll_lock_sequencer #(
    .SYNC_STAGES  (SS),
    .RST_PULSE    (RP),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .locked    (locked),
    .pll_rst   (pll_rst),
    .core_reset(core_reset),
    .ready     (ready),
    .state     (state),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: phase, cycles spent in it, event counts, and the locked
  // samples still travelling through the synchronizer.
  int m_phase = 0;
  int m_dwell = 0;
  int m_retry = 0;
  int m_loss  = 0;
  bit lk_hist[$];
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit r, input bit l);
    bit lk;
    int nph;
    if (r) begin
      m_phase = 0;
      m_dwell = 0;
      m_retry = 0;
      m_loss  = 0;
      lk_hist = {};
      repeat (SS) lk_hist.push_back(1'b0);
      return;
    end
    lk = lk_hist.pop_front();
    lk_hist.push_back(l);
    nph = m_phase;
    case (m_phase)
      0: if (m_dwell + 1 == int'(RP)) nph = 1;
      1: begin
        if (lk) nph = 2;
        else if (m_dwell + 1 == int'(LT)) begin
          nph = 0;
          m_retry = (m_retry < 255) ? m_retry + 1 : 255;
        end
      end
      2: begin
        if (!lk) nph = 1;
        else if (m_dwell + 1 == int'(SC)) nph = 3;
      end
      default: begin
        if (!lk) begin
          nph = 0;
          m_loss = (m_loss < 255) ? m_loss + 1 : 255;
        end
      end
    endcase
    m_dwell = (nph == m_phase) ? m_dwell + 1 : 0;
    m_phase = nph;
  endtask

  // One clock: apply inputs, advance the model on the edge, compare mid-cycle.
  task automatic step(input bit r, input bit l);
    rst    = r;
    locked = l;
    @(posedge refclk);
    model_edge(r, l);
    cyc++;
    @(negedge refclk);
    check_eq("state", 32'(state), 32'(m_phase));
    check_eq("pll_rst", 32'(pll_rst), 32'(m_phase == 0));
    check_eq("core_reset", 32'(core_reset), 32'(m_phase != 3));
    check_eq("ready", 32'(ready), 32'(m_phase == 3));
    check_eq("retry_cnt", 32'(retry_cnt), 32'(m_retry));
    check_eq("loss_cnt", 32'(loss_cnt), 32'(m_loss));
  endtask

  int n;
  int t_abort;
  int t_run;
  int run_left;
  bit lvl;
  bit saw_abort;
  logic [1:0] prev_state;

  initial begin
    repeat (SS) lk_hist.push_back(1'b0);

    // Clean bring-up
    repeat (3) step(1'b1, 1'b0);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_pll_rst", 32'(pll_rst), 32'd1);
    check_eq("rst_core_reset", 32'(core_reset), 32'd1);
    check_eq("rst_ready", 32'(ready), 32'd0);
    n = 0;
    while (pll_rst && n < 50) begin step(1'b0, 1'b0); n++; end
    check_eq("bringup_pulse_len", 32'(n), 32'(RP));
    n = 0;
    while (core_reset && n < 100) begin n++; step(1'b0, n >= 4); end
    check_eq("bringup_release_lat", 32'(n), 32'(3 + SS + 1 + SC));
    check_eq("bringup_ready", 32'(ready), 32'd1);
    check_eq("bringup_retry", 32'(retry_cnt), 32'd0);
    check_eq("bringup_loss", 32'(loss_cnt), 32'd0);

    // Loss in RUN, twice, each followed by a full re-sequence
    for (int k = 1; k <= 2; k++) begin
      step(1'b0, 1'b0);
      n = 1;
      while (!pll_rst && n < 20) begin n++; step(1'b0, 1'b1); end
      check_eq("loss_react_lat", 32'(n), 32'(SS + 1));
      check_eq("loss_core_reset", 32'(core_reset), 32'd1);
      check_eq("loss_cnt_val", 32'(loss_cnt), 32'(k));
      n = 0;
      while (!ready && n < 200) begin step(1'b0, 1'b1); n++; end
      check_eq("loss_reseq_ready", 32'(ready), 32'd1);
    end

    // Reset mid-operation
    step(1'b1, 1'b1);
    check_eq("midrst_state", 32'(state), 32'd0);
    check_eq("midrst_pll_rst", 32'(pll_rst), 32'd1);
    check_eq("midrst_ready", 32'(ready), 32'd0);
    check_eq("midrst_loss", 32'(loss_cnt), 32'd0);
    check_eq("midrst_retry", 32'(retry_cnt), 32'd0);
    n = 0;
    while (pll_rst && n < 50) begin step(1'b0, 1'b1); n++; end
    check_eq("midrst_pulse_len", 32'(n), 32'(RP));

    // Timeout retries and saturation
    repeat (2) step(1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      repeat (RP + LT) step(1'b0, 1'b0);
      check_eq("retry_step", 32'(retry_cnt), 32'(k));
      check_eq("retry_state", 32'(state), 32'd0);
    end
    repeat (252 * (RP + LT)) step(1'b0, 1'b0);
    check_eq("retry_sat", 32'(retry_cnt), 32'd255);
    repeat (2 * (RP + LT)) step(1'b0, 1'b0);
    check_eq("retry_sat_hold", 32'(retry_cnt), 32'd255);

    // Glitchy lock aborts qualification without a retry
    repeat (2) step(1'b1, 1'b0);
    repeat (RP) step(1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    saw_abort = 1'b0;
    t_abort = 0;
    t_run = 0;
    n = 0;
    prev_state = state;
    while (!ready && n < 60) begin
      step(1'b0, 1'b1);
      n++;
      if (prev_state == 2'd2 && state == 2'd1) begin saw_abort = 1'b1; t_abort = cyc; end
      prev_state = state;
    end
    t_run = cyc;
    check_eq("glitch_abort", 32'(saw_abort), 32'd1);
    check_eq("glitch_requal_len", 32'(t_run - t_abort), 32'(1 + SC));
    check_eq("glitch_retry", 32'(retry_cnt), 32'd0);

    // Lock arriving on the timeout cycle, then loss on the terminal STABLE cycle
    repeat (2) step(1'b1, 1'b0);
    repeat (RP) step(1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) step(1'b0, i >= 18);
    check_eq("tie_wait_state", 32'(state), 32'd2);
    check_eq("tie_wait_retry", 32'(retry_cnt), 32'd0);
    for (int i = 21; i <= 28; i++) step(1'b0, i < 26);
    check_eq("tie_stable_state", 32'(state), 32'd1);

    // Randomized lock behaviour with occasional resets
    step(1'b1, 1'b0);
    run_left = 0;
    lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        lvl = ($urandom_range(0, 3) != 0);
        run_left = $urandom_range(1, 60);
      end
      step($urandom_range(0, 299) == 0, lvl);
      run_left--;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
